i2c_master: RTL and testbench
=============================

// Module: i2c_master
// PURPOSE
// - Write-only I2C master with an internal command FIFO. Each FIFO entry is {addr[6:0], data[7:0]} (15 bits).
// - The host pushes entries with fifo_wr_en. A pop via fifo_rd_en starts one single-byte I2C write transaction.
// - Frame: START, 7-bit address + R/W=0, ACK slot, 8 data bits, ACK slot, STOP.
// - Sits between a local control/config block and the board I2C pins.
// PARAMETERS
// - FIFO_DEPTH  8  number of 15-bit entries; power of 2, >=2
// - CLK_DIV     1  clk cycles per SCL quarter-period (>=1); one I2C bit = 4*CLK_DIV clk
// PORTS
// - clk         in   1   system clock, all logic on rising edge
// - arst        in   1   asynchronous, active-low reset
// - data        in   8   data byte, captured on push
// - addr        in   7   7-bit slave address, captured on push
// - fifo_wr_en  in   1   push {addr,data} when high at clk edge and !fifo_full
// - fifo_rd_en  in   1   pop head entry and start transaction when high, fsm_ready=1, !fifo_empty
// - fifo_empty  out  1   FIFO holds 0 entries
// - fifo_full   out  1   FIFO holds FIFO_DEPTH entries
// - fsm_ready   out  1   high only in IDLE
// - i2c_sda     out  1   serial data, push-pull; '1' = released/high
// - i2c_scl     out  1   serial clock, push-pull; idles high
// BEHAVIOUR
// - Reset (arst=0, async): FIFO pointers and count cleared, FSM->IDLE, divider cleared.
//   Outputs: i2c_sda=1, i2c_scl=1, fsm_ready=1, fifo_empty=1, fifo_full=0. Stored FIFO contents need no reset.
// - Reset mid-transaction aborts immediately; both lines return high with no STOP sequence.
// - FIFO: synchronous. Registered count drives flags.
//   - Push while full: ignored.
//   - Pop while empty or while !fsm_ready: ignored (no pointer change).
//   - Push and accepted pop in the same cycle: count unchanged, both pointers advance, wrap mod FIFO_DEPTH.
//   - Push then pop of the same entry two edges later pops that entry.
// - Accepted pop at edge N: head word loaded into the tx register at edge N; FSM leaves IDLE at edge N, so fsm_ready=0 from N.
// - Quarter tick: strobe every CLK_DIV clk while busy; divider held at 0 in IDLE. Each bit has phases q0..q3:
//   - q0: SCL low, drive SDA
//   - q1: SCL high
//   - q2: SCL high, SDA stable
//   - q3: SCL low
// - FSM states and transitions:
//   - IDLE: SCL=1, SDA=1.
//   - START: SDA 1->0 at q1 while SCL high; SCL falls at q3.
//   - ADDR: 8 bits MSB first, addr[6:0] then R/W=0.
//   - ADDR_ACK: SDA released (1) for one bit; ACK is not sampled (SDA is output-only); always continue.
//   - DATA: 8 bits data[7:0], MSB first.
//   - DATA_ACK: as ADDR_ACK.
//   - STOP: SDA=0 at q0, SCL high at q1, SDA 0->1 at q2.
//   - Then back to IDLE; fsm_ready=1 on the next edge.
// - Transaction length: 20 bit-times = 80*CLK_DIV clk, from pop to fsm_ready=1.
// - SDA changes only while SCL is low, except the START/STOP edges.
// - No chaining: a queued entry waits for the next fifo_rd_en.
// - fifo_wr_en and fifo_rd_en are sampled every cycle; level-sensitive, one action per high cycle.
// TESTING
// - Reset with arst=0 -> sda=1, scl=1, fsm_ready=1, fifo_empty=1, fifo_full=0; hold stays stable.
// - Push addr=0x50, data=0xA5, then pulse rd_en -> SDA serial 1010000_0, Z(1), 10100101, Z(1) on SCL rising edges;
//   START/STOP correct; fsm_ready back high after 80 clk.
// - Push FIFO_DEPTH entries -> fifo_full=1; extra push ignored; pops return entries in order.
// - rd_en while busy or empty -> no pop, count unchanged, fsm_ready unaffected.
// - Simultaneous wr_en+rd_en with 1 entry -> transaction uses old head, count stays 1.
// - 4x (push random addr/data, wait 20 clk, rd_en) -> each frame bit-exact to its entry; flags consistent.

Source files
------------

// File: rtl/i2c_master.sv
// i2c_master: write-only I2C master fed by a {addr,data} command FIFO; one pop = one single-byte write frame.
// Rev 1.0
`default_nettype none

module i2c_master #(
  parameter int FIFO_DEPTH = 8,
  parameter int CLK_DIV    = 1
) (
  input  logic       clk,
  input  logic       arst,
  input  logic [7:0] data,
  input  logic [6:0] addr,
  input  logic       fifo_wr_en,
  input  logic       fifo_rd_en,
  output logic       fifo_empty,
  output logic       fifo_full,
  output logic       fsm_ready,
  output logic       i2c_sda,
  output logic       i2c_scl
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    ADDR     = 3'd2,
    ADDR_ACK = 3'd3,
    DATA     = 3'd4,
    DATA_ACK = 3'd5,
    STOP     = 3'd6
  } state_t;

  logic [14:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  state_t        state;
  state_t        state_next;
  logic [1:0]    phase;
  logic [DW-1:0] div;
  logic [2:0]    bit_cnt;
  logic [14:0]   tx;
  logic          tick;
  logic          bit_end;
  logic [2:0]    bit_idx;
  logic [7:0]    addr_byte;
  logic [7:0]    data_byte;
  logic          bit_scl;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign fsm_ready  = (state == IDLE);
  assign push       = fifo_wr_en && !fifo_full;
  assign pop        = fifo_rd_en && fsm_ready && !fifo_empty;

  // Storage is deliberately unreset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {addr, data};
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign tick      = (div == DW'(CLK_DIV - 1));
  assign bit_end   = tick && (phase == 2'd3) && (state != IDLE);
  assign bit_idx   = 3'd7 - bit_cnt;
  assign addr_byte = {tx[14:8], 1'b0};
  assign data_byte = tx[7:0];
  assign bit_scl   = phase[0] ^ phase[1];

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state   <= IDLE;
      phase   <= 2'd0;
      div     <= '0;
      bit_cnt <= 3'd0;
      tx      <= '0;
    end else begin
      state <= state_next;
      if (pop) tx <= mem[rd_ptr];
      if (state == IDLE) begin
        div     <= '0;
        phase   <= 2'd0;
        bit_cnt <= 3'd0;
      end else begin
        div <= tick ? '0 : div + DW'(1);
        if (tick) phase <= phase + 2'd1;
        // Bit counter restarts whenever the FSM moves to a new field.
        if (bit_end) bit_cnt <= (state_next != state) ? 3'd0 : bit_cnt + 3'd1;
      end
    end
  end

  always_comb begin
    state_next = state;
    i2c_scl    = 1'b1;
    i2c_sda    = 1'b1;
    unique case (state)
      IDLE: begin
        if (pop) state_next = START;
      end
      START: begin
        i2c_scl = (phase != 2'd3);
        i2c_sda = (phase == 2'd0);
        if (bit_end) state_next = ADDR;
      end
      ADDR: begin
        i2c_scl = bit_scl;
        i2c_sda = addr_byte[bit_idx];
        if (bit_end && (bit_cnt == 3'd7)) state_next = ADDR_ACK;
      end
      ADDR_ACK: begin
        i2c_scl = bit_scl;
        if (bit_end) state_next = DATA;
      end
      DATA: begin
        i2c_scl = bit_scl;
        i2c_sda = data_byte[bit_idx];
        if (bit_end && (bit_cnt == 3'd7)) state_next = DATA_ACK;
      end
      DATA_ACK: begin
        i2c_scl = bit_scl;
        if (bit_end) state_next = STOP;
      end
      STOP: begin
        i2c_scl = (phase != 2'd0);
        i2c_sda = phase[1];
        if (bit_end) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_i2c_master.sv
// tb_i2c_master: table-driven FIFO/flag vectors plus a bus monitor scoring decoded frames against a queue.
`default_nettype none

module tb_i2c_master;

  localparam int FIFO_DEPTH = 8;
  localparam int CLK_DIV    = 1;
  localparam int TXN        = 80 * CLK_DIV;

  logic       clk = 1'b0;
  logic       arst = 1'b1;
  logic [7:0] data = 8'h00;
  logic [6:0] addr = 7'h00;
  logic       fifo_wr_en = 1'b0;
  logic       fifo_rd_en = 1'b0;
  logic       fifo_empty;
  logic       fifo_full;
  logic       fsm_ready;
  logic       i2c_sda;
  logic       i2c_scl;

  always #5 clk = ~clk;

  i2c_master #(.FIFO_DEPTH(FIFO_DEPTH), .CLK_DIV(CLK_DIV)) dut (
    .clk        (clk),
    .arst       (arst),
    .data       (data),
    .addr       (addr),
    .fifo_wr_en (fifo_wr_en),
    .fifo_rd_en (fifo_rd_en),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full),
    .fsm_ready  (fsm_ready),
    .i2c_sda    (i2c_sda),
    .i2c_scl    (i2c_scl)
  );

  typedef struct {
    logic       wr;
    logic       rd;
    logic [6:0] a;
    logic [7:0] d;
    logic       e_empty;
    logic       e_full;
    logic       e_ready;
  } vec_t;

  vec_t        tbl [10];
  int          checks = 0;
  int          errors = 0;
  logic [14:0] mq [$];
  logic [18:0] exp_q [$];
  int          cyc = 0;
  int          busy_end = 0;
  int          frames_exp = 0;
  int          frames_seen = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Bits seen on SCL rising edges: addr, R/W=0, ack=1, data, ack=1, then the STOP slot's rising edge with SDA low.
  function automatic logic [18:0] frame_of(input logic [14:0] e);
    return {e[14:8], 1'b0, 1'b1, e[7:0], 1'b1, 1'b0};
  endfunction

  task automatic step(input logic wr, input logic rd, input logic [6:0] a, input logic [7:0] d);
    logic        ready_before;
    logic        do_pop;
    logic        do_push;
    logic [14:0] head;
    ready_before = (cyc >= busy_end);
    do_pop  = rd && ready_before && (mq.size() != 0);
    do_push = wr && (mq.size() < FIFO_DEPTH);
    fifo_wr_en = wr;
    fifo_rd_en = rd;
    addr = a;
    data = d;
    @(posedge clk);
    #1;
    cyc++;
    fifo_wr_en = 1'b0;
    fifo_rd_en = 1'b0;
    if (do_pop) begin
      head = mq.pop_front();
      exp_q.push_back(frame_of(head));
      frames_exp++;
      busy_end = cyc + TXN;
    end
    if (do_push) mq.push_back({a, d});
    check("empty", fifo_empty, mq.size() == 0);
    check("full", fifo_full, mq.size() == FIFO_DEPTH);
    check("ready", fsm_ready, cyc >= busy_end);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 7'h00, 8'h00);
  endtask

  task automatic wait_idle();
    while (cyc < busy_end) step(1'b0, 1'b0, 7'h00, 8'h00);
  endtask

  // Bus monitor: decodes START / bits / STOP and scores each frame.
  initial begin
    logic        p_scl;
    logic        p_sda;
    logic        in_frame;
    int          nb;
    logic [18:0] sh;
    p_scl = 1'b1;
    p_sda = 1'b1;
    in_frame = 1'b0;
    nb = 0;
    sh = '0;
    forever begin
      @(negedge clk);
      if (!arst) begin
        in_frame = 1'b0;
        p_scl = 1'b1;
        p_sda = 1'b1;
      end else begin
        if (!in_frame && p_scl && p_sda && i2c_scl && !i2c_sda) begin
          in_frame = 1'b1;
          nb = 0;
          sh = '0;
        end else if (in_frame && p_scl && !p_sda && i2c_scl && i2c_sda) begin
          in_frame = 1'b0;
          frames_seen++;
          check("frame_bits", nb, 19);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL frame_unexpected: got %0h expected none", sh);
          end else begin
            check("frame", sh, exp_q.pop_front());
          end
        end else if (in_frame && !p_scl && i2c_scl) begin
          sh = {sh[17:0], i2c_sda};
          nb++;
        end else if (in_frame && p_scl && i2c_scl && (p_sda != i2c_sda)) begin
          check("sda_stable_scl_high", i2c_sda, p_sda);
        end else if (!in_frame) begin
          check("idle_scl", i2c_scl, 1'b1);
          check("idle_sda", i2c_sda, 1'b1);
        end
        p_scl = i2c_scl;
        p_sda = i2c_sda;
      end
    end
  end

  initial begin
    logic [6:0] ra;
    logic [7:0] rd8;

    tbl[0] = '{1'b0, 1'b1, 7'h00, 8'h00, 1'b1, 1'b0, 1'b1};
    for (int i = 1; i <= FIFO_DEPTH; i++)
      tbl[i] = '{1'b1, 1'b0, 7'(16 + i), 8'(48 + 7 * i), 1'b0, (i == FIFO_DEPTH), 1'b1};
    tbl[9] = '{1'b1, 1'b0, 7'h7F, 8'hFF, 1'b0, 1'b1, 1'b1};

    #1 arst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_sda", i2c_sda, 1'b1);
      check("rst_scl", i2c_scl, 1'b1);
      check("rst_ready", fsm_ready, 1'b1);
      check("rst_empty", fifo_empty, 1'b1);
      check("rst_full", fifo_full, 1'b0);
    end
    arst = 1'b1;

    // Pop on empty, fill to full, push on full.
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].wr, tbl[i].rd, tbl[i].a, tbl[i].d);
      check("tbl_empty", fifo_empty, tbl[i].e_empty);
      check("tbl_full", fifo_full, tbl[i].e_full);
      check("tbl_ready", fsm_ready, tbl[i].e_ready);
    end

    // Drain in order, with a rejected pop attempt while busy, back-to-back at the ready edge.
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      step(1'b0, 1'b1, 7'h00, 8'h00);
      idle(10);
      step(1'b0, 1'b1, 7'h00, 8'h00);
      wait_idle();
    end
    step(1'b0, 1'b1, 7'h00, 8'h00);

    // Reference frame 0x50 / 0xA5.
    step(1'b1, 1'b0, 7'h50, 8'hA5);
    step(1'b0, 1'b1, 7'h00, 8'h00);
    wait_idle();

    // Simultaneous push and pop with one entry queued.
    step(1'b1, 1'b0, 7'h11, 8'h22);
    step(1'b1, 1'b1, 7'h33, 8'h44);
    check("simul_count1", fifo_empty, 1'b0);
    wait_idle();
    step(1'b0, 1'b1, 7'h00, 8'h00);
    wait_idle();

    for (int k = 0; k < 4; k++) begin
      ra  = 7'($urandom);
      rd8 = 8'($urandom);
      step(1'b1, 1'b0, ra, rd8);
      idle(20);
      step(1'b0, 1'b1, 7'h00, 8'h00);
      wait_idle();
    end

    // Asynchronous reset in the middle of a frame.
    step(1'b1, 1'b0, 7'h2B, 8'h3C);
    step(1'b1, 1'b0, 7'h4D, 8'h5E);
    step(1'b0, 1'b1, 7'h00, 8'h00);
    idle(30);
    #2 arst = 1'b0;
    #1;
    check("abort_sda", i2c_sda, 1'b1);
    check("abort_scl", i2c_scl, 1'b1);
    check("abort_ready", fsm_ready, 1'b1);
    check("abort_empty", fifo_empty, 1'b1);
    check("abort_full", fifo_full, 1'b0);
    mq.delete();
    exp_q.delete();
    frames_exp--;
    busy_end = cyc;
    @(posedge clk);
    #1 arst = 1'b1;

    step(1'b1, 1'b0, 7'h6A, 8'h81);
    step(1'b0, 1'b1, 7'h00, 8'h00);
    wait_idle();
    idle(4);

    check("pending_frames", exp_q.size(), 0);
    check("frame_count", frames_seen, frames_exp);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
